cfu_issue_unit: RTL and testbench
=================================

# cfu_issue_unit

Consumes CFU request entries from the request-side `cfu_fifo_interface` and issues them to the external custom function unit over a valid/ready request channel. It tracks outstanding tags, accepts tagged CFU responses, and forwards them to the writeback side over a registered valid/ready response port. It sits directly downstream of the CFU request FIFO and upstream of CFU writeback arbitration.

## Interface
Parameters:
- `DATA_WIDTH`, default 42: FIFO entry width. Must equal `TAG_W + FUNCT_W + XLEN` (4+6+32).
- `MAX_OUTSTANDING`, default 4: the maximum number of popped but unretired requests (1..16).

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `req_fifo` `cfu_fifo_interface.master`: this block drives `pop`. It ties `push`, `potential_push` and `data_in` to 0. It reads `valid` and `data_out`, packed as {tag[41:38], funct[37:32], operand[31:0]}.
- `cfu_req_valid` out 1: the request register holds an entry.
- `cfu_req_ready` in 1: the CFU accepts the request.
- `cfu_req_tag` out 4, `cfu_req_funct` out 6, `cfu_req_operand` out 32: the request payload.
- `cfu_rsp_valid` in 1, `cfu_rsp_tag` in 4, `cfu_rsp_data` in 32: the CFU response.
- `cfu_rsp_ready` out 1: this block accepts the response.
- `rsp_valid` out 1, `rsp_tag` out 4, `rsp_data` out 32: the forwarded response.
- `rsp_ready` in 1: the writeback side accepts the response.
- `flush` in 1: a single-cycle drain request.
- `idle` out 1: no work in flight.
- `tag_error` out 1: a one-cycle pulse on a response whose tag is not outstanding.
- `outstanding` out `$clog2(MAX_OUTSTANDING+1)`: the current in-flight count.

## Operation
- **Reset:** All outputs are 0. The state is RUN, the tag table is all-clear, and the count is 0.
- **Tag table:** A 16-bit vector with one bit per tag. A bit is set on pop and cleared on response accept.
- **Count:** Increments on pop and decrements on response accept. Both in the same cycle leave it unchanged.
- **Pop condition:** `pop = req_fifo.valid && state==RUN && (!cfu_req_valid || cfu_req_ready) && outstanding < MAX_OUTSTANDING && !table[data_out.tag]`.
  - The hazard check uses the registered table.
  - A tag retired in cycle N can be re-popped in cycle N+1 at the earliest, never in the same cycle.
- **Request register:**
  - Loads the payload on pop and sets `cfu_req_valid`.
  - Clears on `cfu_req_ready` if there is no concurrent pop.
  - Payload is stable while `cfu_req_valid && !cfu_req_ready`.
- **Response path:**
  - `cfu_rsp_ready = !rsp_valid || rsp_ready`, i.e. a single registered output.
  - On accept with the tag set in the table: clear the tag, load `rsp_tag`/`rsp_data`, and set `rsp_valid`.
  - On accept with the tag clear: pulse `tag_error`, drop the data, change neither the count nor the table, and leave `rsp_valid` unchanged.
- **FSM:**
  - RUN: normal operation. `flush` moves to DRAIN.
  - DRAIN: no pops. A held request still issues and responses still retire. The block returns to RUN in the cycle after `outstanding==0 && !cfu_req_valid && !rsp_valid`. `flush` while in DRAIN is ignored.
  - `flush` and a pop eligible in the same cycle: the flush wins, so no pop occurs.
- **idle** = `state==RUN && outstanding==0 && !cfu_req_valid && !rsp_valid`.
- **Reset mid-operation:** Drops the held request and response, clears the table and count, and returns to RUN. The FIFO contents are not this block's concern.

## Timing
- Pop in cycle N gives `cfu_req_valid` in N+1.
- CFU response handshake in cycle N gives `rsp_valid` in N+1.
- The `tag_error` pulse is registered and asserts in N+1.
- Sustained throughput is 1 request/cycle and 1 response/cycle when ready and tags are distinct.
- Back-to-back pops with `cfu_req_ready` held high do not bubble.
- `pop` is combinational from `req_fifo.valid`/`data_out` and the registered state. There is no combinational path from `cfu_rsp_*` to `pop`.
- `cfu_rsp_ready` is combinational from `rsp_ready` only.

## Structure
- **`cfu_pkg`** holds:
  - `TAG_W=4`, `FUNCT_W=6`, `XLEN=32`.
  - A packed struct `cfu_req_t {tag, funct, operand}` (42 bits, cast from `data_out`).
  - `cfu_rsp_t {tag, data}`.
  - The enum `cfu_issue_state_t {RUN, DRAIN}`.
- **`cfu_tag_tracker`** is the one natural sub-module. It owns the tag vector and the count. Its inputs are set-tag/valid and clear-tag/valid. Its outputs are the busy vector, the count and the at-limit flag. The top owns the FSM and the registers.

## Test plan
- **Single op:** Push {tag=3, funct=0x05, operand=0x1234_5678} with `cfu_req_ready=1`. The CFU answers tag 3, data 0xCAFE_F00D. Required: `cfu_req_valid` one cycle after pop with the exact payload, and `rsp_valid` with tag 3 and data 0xCAFEF00D one cycle after the response. `outstanding` goes 0→1→0 and `idle` returns high.
- **Credit limit:** Queue 6 entries with tags 0..5, `MAX_OUTSTANDING=4`, and no responses. Required: exactly 4 pops and `outstanding=4`. Retiring tag 1 allows the 5th pop on the following cycle.
- **Tag hazard:** Push tag 7 twice. Required: the second pop stalls until tag 7's response is accepted, then pops exactly one cycle later.
- **Backpressure:** Hold `cfu_req_ready=0` for 5 cycles. Required: the payload is stable and no further pop occurs. Hold `rsp_ready=0`. Required: `cfu_rsp_ready=0` and `rsp_data` is stable.
- **Bogus tag:** Send a CFU response with tag 9 while nothing is outstanding. Required: a 1-cycle `tag_error` pulse, no `rsp_valid`, and `outstanding` unchanged.
- **Flush:** Assert `flush` with 2 ops in flight and FIFO `valid=1`. Required: no pops until both retire and `rsp_valid` drains, a return to RUN, then popping resumes. Assert `rst` mid-flush. Required: all outputs are 0 the next cycle.

Source files
------------

// File: rtl/cfu_pkg.sv
// ---------------------------------------------------------------------------
// cfu_pkg
//
// Shared types and sizes for the CFU issue path.
//   TAG_W / FUNCT_W / XLEN : field widths of a CFU request entry
//   REQ_W                  : width of one packed request FIFO entry
//   NUM_TAGS               : size of the tag space (one tracker bit per tag)
//   cfu_req_t              : {tag, funct, operand}, the FIFO entry layout
//   cfu_rsp_t              : {tag, data}, a CFU response
//   cfu_issue_state_t      : RUN / DRAIN issue state
// ---------------------------------------------------------------------------
package cfu_pkg;

    localparam int TAG_W    = 4;
    localparam int FUNCT_W  = 6;
    localparam int XLEN     = 32;
    localparam int REQ_W    = TAG_W + FUNCT_W + XLEN;
    localparam int NUM_TAGS = 1 << TAG_W;

    typedef struct packed {
        logic [TAG_W-1:0]   tag;
        logic [FUNCT_W-1:0] funct;
        logic [XLEN-1:0]    operand;
    } cfu_req_t;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  data;
    } cfu_rsp_t;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } cfu_issue_state_t;

endpackage

// File: rtl/cfu_fifo_interface.sv
// ---------------------------------------------------------------------------
// cfu_fifo_interface
//
// Handshake bundle between a FIFO and its producer/consumer.
//   push, potential_push, data_in : write side (driven by the master)
//   pop                           : read strobe (driven by the master)
//   valid, data_out               : head-of-queue status and entry (slave)
// The master modport is the side that owns the read strobe; the slave
// modport is the FIFO storage itself.
// ---------------------------------------------------------------------------
interface cfu_fifo_interface
    import cfu_pkg::*;
#(
    parameter int DATA_WIDTH = REQ_W
);

    logic                  push;
    logic                  potential_push;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  pop;
    logic                  valid;
    logic [DATA_WIDTH-1:0] data_out;

    modport master (
        output push,
        output potential_push,
        output data_in,
        output pop,
        input  valid,
        input  data_out
    );

    modport slave (
        input  push,
        input  potential_push,
        input  data_in,
        input  pop,
        output valid,
        output data_out
    );

endinterface

// File: rtl/cfu_tag_tracker.sv
// ---------------------------------------------------------------------------
// cfu_tag_tracker
//
// Book-keeping for requests that have been popped but not yet retired.
//   clk, rst      : clock, synchronous active-high reset
//   set_valid_i   : a request with tag set_tag_i was popped this cycle
//   set_tag_i     : tag to mark busy
//   clr_valid_i   : a response with tag clr_tag_i retired this cycle
//   clr_tag_i     : tag to release
//   busy_o        : one registered bit per tag, 1 = tag in flight
//   count_o       : registered number of in-flight tags
//   at_limit_o    : count_o has reached MAX_OUTSTANDING
//
// Set and clear never target the same tag in one cycle: a pop needs the
// tag free, a retire needs it busy.
// ---------------------------------------------------------------------------
module cfu_tag_tracker
    import cfu_pkg::*;
#(
    parameter  int MAX_OUTSTANDING = 4,
    localparam int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                set_valid_i,
    input  logic [TAG_W-1:0]    set_tag_i,
    input  logic                clr_valid_i,
    input  logic [TAG_W-1:0]    clr_tag_i,
    output logic [NUM_TAGS-1:0] busy_o,
    output logic [CNT_W-1:0]    count_o,
    output logic                at_limit_o
);

    logic [NUM_TAGS-1:0] busy_q, busy_d;
    logic [CNT_W-1:0]    count_q, count_d;

    // Next busy vector and count. A simultaneous pop and retire leave
    // the count where it was.
    always_comb begin
        busy_d  = busy_q;
        count_d = count_q;
        if (set_valid_i) begin
            busy_d[set_tag_i] = 1'b1;
        end
        if (clr_valid_i) begin
            busy_d[clr_tag_i] = 1'b0;
        end
        unique case ({set_valid_i, clr_valid_i})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q  <= '0;
            count_q <= '0;
        end else begin
            busy_q  <= busy_d;
            count_q <= count_d;
        end
    end

    assign busy_o     = busy_q;
    assign count_o    = count_q;
    assign at_limit_o = (count_q >= CNT_W'(MAX_OUTSTANDING));

endmodule

// File: rtl/cfu_issue_unit.sv
// ---------------------------------------------------------------------------
// cfu_issue_unit
//
// Pops CFU requests from the request FIFO, issues them to the custom
// function unit over a registered valid/ready channel, tracks the tags in
// flight and forwards tagged CFU responses to writeback through a single
// registered output stage.
//
// Ports:
//   clk, rst                         : clock, synchronous active-high reset
//   req_fifo (master)                : request FIFO; only pop is driven
//   cfu_req_valid/ready              : request channel handshake to the CFU
//   cfu_req_tag/funct/operand        : request payload
//   cfu_rsp_valid/tag/data           : response from the CFU
//   cfu_rsp_ready                    : response accepted by this block
//   rsp_valid/tag/data, rsp_ready    : forwarded response to writeback
//   flush                            : one-cycle request to stop popping
//                                      until everything in flight drains
//   idle                             : nothing in flight and not draining
//   tag_error                        : pulse for a response with an unknown tag
//   outstanding                      : popped but not yet retired requests
// ---------------------------------------------------------------------------
module cfu_issue_unit
    import cfu_pkg::*;
#(
    parameter  int DATA_WIDTH      = REQ_W,
    parameter  int MAX_OUTSTANDING = 4,
    localparam int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    cfu_fifo_interface.master    req_fifo,
    output logic                 cfu_req_valid,
    input  logic                 cfu_req_ready,
    output logic [TAG_W-1:0]     cfu_req_tag,
    output logic [FUNCT_W-1:0]   cfu_req_funct,
    output logic [XLEN-1:0]      cfu_req_operand,
    input  logic                 cfu_rsp_valid,
    input  logic [TAG_W-1:0]     cfu_rsp_tag,
    input  logic [XLEN-1:0]      cfu_rsp_data,
    output logic                 cfu_rsp_ready,
    output logic                 rsp_valid,
    output logic [TAG_W-1:0]     rsp_tag,
    output logic [XLEN-1:0]      rsp_data,
    input  logic                 rsp_ready,
    input  logic                 flush,
    output logic                 idle,
    output logic                 tag_error,
    output logic [CNT_W-1:0]     outstanding
);

    cfu_issue_state_t    state_q, state_d;
    logic                reqValid_q, reqValid_d;
    cfu_req_t            req_q, req_d;
    logic                rspValid_q, rspValid_d;
    cfu_rsp_t            rsp_q, rsp_d;
    logic                tagError_q, tagError_d;

    logic [DATA_WIDTH-1:0] fifoWord;
    cfu_req_t              head;
    logic [NUM_TAGS-1:0]   tagBusy;
    logic [CNT_W-1:0]      countQ;
    logic                  atLimit;
    logic                  popEn;
    logic                  rspAccept;
    logic                  rspRetire;
    logic                  drained;

    // The FIFO head is reinterpreted as a request entry; a width mismatch
    // between the FIFO and the entry layout fails the cast at elaboration.
    assign fifoWord = req_fifo.data_out;
    assign head     = cfu_req_t'(fifoWord);

    // This block only consumes from the FIFO.
    assign req_fifo.push           = 1'b0;
    assign req_fifo.potential_push = 1'b0;
    assign req_fifo.data_in        = '0;

    // Pop uses only registered state plus the FIFO head, so nothing on the
    // CFU response side can reach it combinationally. A tag retired this
    // cycle is still busy in the registered table and can only be popped
    // again next cycle. Flush beats a same-cycle pop, and reset suppresses
    // pops so the FIFO never loses an entry the tracker is about to forget.
    assign popEn = !rst
                && req_fifo.valid
                && (state_q == RUN)
                && !flush
                && (!reqValid_q || cfu_req_ready)
                && !atLimit
                && !tagBusy[head.tag];

    assign req_fifo.pop = popEn;

    // The response stage is one register deep, so it can take a new
    // response whenever it is empty or being drained this cycle.
    assign cfu_rsp_ready = !rspValid_q || rsp_ready;
    assign rspAccept     = cfu_rsp_valid && cfu_rsp_ready;
    assign rspRetire     = rspAccept && tagBusy[cfu_rsp_tag];

    assign drained = (countQ == '0) && !reqValid_q && !rspValid_q;

    cfu_tag_tracker #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) u_tag_tracker (
        .clk         (clk),
        .rst         (rst),
        .set_valid_i (popEn),
        .set_tag_i   (head.tag),
        .clr_valid_i (rspRetire),
        .clr_tag_i   (cfu_rsp_tag),
        .busy_o      (tagBusy),
        .count_o     (countQ),
        .at_limit_o  (atLimit)
    );

    // RUN/DRAIN next state. A flush received while already draining has
    // nothing further to do. Draining ends once no request is held, no
    // response is buffered and the tracker is empty.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN: begin
                if (flush) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (drained) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // Request register: loaded on pop, otherwise emptied when the CFU takes
    // it. While the CFU stalls, neither branch fires, so the payload holds.
    always_comb begin
        reqValid_d = reqValid_q;
        req_d      = req_q;
        if (popEn) begin
            reqValid_d = 1'b1;
            req_d      = head;
        end else if (cfu_req_ready) begin
            reqValid_d = 1'b0;
        end
    end

    // Response register: only responses for a tag in flight are forwarded.
    // An unknown tag is swallowed and reported through tag_error, leaving
    // the buffered response (if any) to follow its own handshake.
    always_comb begin
        rspValid_d = rspValid_q;
        rsp_d      = rsp_q;
        tagError_d = rspAccept && !tagBusy[cfu_rsp_tag];
        if (rspRetire) begin
            rspValid_d = 1'b1;
            rsp_d.tag  = cfu_rsp_tag;
            rsp_d.data = cfu_rsp_data;
        end else if (rsp_ready) begin
            rspValid_d = 1'b0;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            reqValid_q <= 1'b0;
            req_q      <= '0;
            rspValid_q <= 1'b0;
            rsp_q      <= '0;
            tagError_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            reqValid_q <= reqValid_d;
            req_q      <= req_d;
            rspValid_q <= rspValid_d;
            rsp_q      <= rsp_d;
            tagError_q <= tagError_d;
        end
    end

    assign cfu_req_valid   = reqValid_q;
    assign cfu_req_tag     = req_q.tag;
    assign cfu_req_funct   = req_q.funct;
    assign cfu_req_operand = req_q.operand;
    assign rsp_valid       = rspValid_q;
    assign rsp_tag         = rsp_q.tag;
    assign rsp_data        = rsp_q.data;
    assign tag_error       = tagError_q;
    assign outstanding     = countQ;
    assign idle            = (state_q == RUN) && drained;

endmodule

// File: tb/tb_cfu_issue_unit.sv
// ---------------------------------------------------------------------------
// tb_cfu_issue_unit
//
// Bench for cfu_issue_unit. The bench plays the request FIFO (a queue of
// packed entries), the CFU (a list of issued tags it may answer) and the
// writeback consumer. A reference model tracks held request, tags in
// flight, count, buffered response and drain mode as plain variables.
// ---------------------------------------------------------------------------
module tb_cfu_issue_unit;
    import cfu_pkg::*;

    localparam int MAXO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        cfu_req_ready;
    logic        cfu_rsp_valid;
    logic [3:0]  cfu_rsp_tag;
    logic [31:0] cfu_rsp_data;
    logic        rsp_ready;

    logic        cfu_req_valid;
    logic [3:0]  cfu_req_tag;
    logic [5:0]  cfu_req_funct;
    logic [31:0] cfu_req_operand;
    logic        cfu_rsp_ready;
    logic        rsp_valid;
    logic [3:0]  rsp_tag;
    logic [31:0] rsp_data;
    logic        idle;
    logic        tag_error;
    logic [2:0]  outstanding;

    cfu_fifo_interface #(.DATA_WIDTH(42)) fifoIf ();

    cfu_issue_unit #(
        .DATA_WIDTH      (42),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .req_fifo        (fifoIf.master),
        .cfu_req_valid   (cfu_req_valid),
        .cfu_req_ready   (cfu_req_ready),
        .cfu_req_tag     (cfu_req_tag),
        .cfu_req_funct   (cfu_req_funct),
        .cfu_req_operand (cfu_req_operand),
        .cfu_rsp_valid   (cfu_rsp_valid),
        .cfu_rsp_tag     (cfu_rsp_tag),
        .cfu_rsp_data    (cfu_rsp_data),
        .cfu_rsp_ready   (cfu_rsp_ready),
        .rsp_valid       (rsp_valid),
        .rsp_tag         (rsp_tag),
        .rsp_data        (rsp_data),
        .rsp_ready       (rsp_ready),
        .flush           (flush),
        .idle            (idle),
        .tag_error       (tag_error),
        .outstanding     (outstanding)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // FIFO contents and CFU-side list of issued, unanswered tags.
    logic [41:0] fifoQ[$];
    logic [3:0]  pendingQ[$];

    // Reference model.
    bit          mReqValid;
    logic [41:0] mReq;
    bit          mBusy[16];
    int          mCount;
    bit          mRspValid;
    logic [3:0]  mRspTag;
    logic [31:0] mRspData;
    bit          mTagErr;
    bit          mDrain;

    bit expPop;
    bit obsPop;

    task automatic modelReset();
        mReqValid = 0;
        mReq      = '0;
        for (int i = 0; i < 16; i++) mBusy[i] = 0;
        mCount    = 0;
        mRspValid = 0;
        mRspTag   = '0;
        mRspData  = '0;
        mTagErr   = 0;
        mDrain    = 0;
        pendingQ.delete();
    endtask

    task automatic refreshFifo();
        fifoIf.valid    = (fifoQ.size() > 0);
        fifoIf.data_out = (fifoQ.size() > 0) ? fifoQ[0] : 42'd0;
    endtask

    task automatic pushEntry(input logic [3:0] t, input logic [5:0] f, input logic [31:0] op);
        fifoQ.push_back({t, f, op});
        refreshFifo();
    endtask

    // One clock: decide what should happen from the model and the current
    // inputs (sampled at the falling edge), then advance the FIFO and the
    // model just after the rising edge.
    task automatic tick();
        bit          haveHead;
        logic [41:0] head;
        bit          accept;
        bit          hit;
        bit          issue;
        logic [3:0]  issueTag;
        logic [3:0]  rTag;
        logic [31:0] rData;
        bit          reqReady;
        bit          wbReady;
        bit          flushIn;
        bit          rstIn;
        @(negedge clk);
        haveHead = (fifoQ.size() > 0);
        head     = haveHead ? fifoQ[0] : 42'd0;
        reqReady = cfu_req_ready;
        wbReady  = rsp_ready;
        flushIn  = flush;
        rstIn    = rst;
        expPop   = !rstIn && haveHead && !mDrain && !flushIn
                && (!mReqValid || reqReady) && (mCount < MAXO) && !mBusy[head[41:38]];
        obsPop   = fifoIf.pop;
        accept   = cfu_rsp_valid && (!mRspValid || wbReady);
        hit      = accept && mBusy[cfu_rsp_tag];
        rTag     = cfu_rsp_tag;
        rData    = cfu_rsp_data;
        issue    = mReqValid && reqReady;
        issueTag = mReq[41:38];
        @(posedge clk);
        #1;
        if (obsPop && fifoQ.size() > 0) void'(fifoQ.pop_front());
        refreshFifo();
        if (rstIn) begin
            modelReset();
        end else begin
            if (!mDrain && flushIn) mDrain = 1;
            else if (mDrain && mCount == 0 && !mReqValid && !mRspValid) mDrain = 0;
            if (issue) pendingQ.push_back(issueTag);
            if (hit) begin
                for (int i = 0; i < pendingQ.size(); i++) begin
                    if (pendingQ[i] == rTag) begin
                        pendingQ.delete(i);
                        break;
                    end
                end
                mBusy[rTag] = 0;
                mCount--;
            end
            if (expPop) begin
                mReqValid = 1;
                mReq      = head;
                mBusy[head[41:38]] = 1;
                mCount++;
            end else if (reqReady) begin
                mReqValid = 0;
            end
            if (hit) begin
                mRspValid = 1;
                mRspTag   = rTag;
                mRspData  = rData;
            end else if (wbReady) begin
                mRspValid = 0;
            end
            mTagErr = accept && !hit;
        end
    endtask

    // Answer every issued tag until the FIFO, the DUT and the model are empty.
    task automatic drainAll();
        int guard;
        guard         = 0;
        flush         = 0;
        cfu_req_ready = 1;
        rsp_ready     = 1;
        while (!(fifoQ.size() == 0 && mCount == 0 && !mReqValid && !mRspValid && !mDrain)
               && guard < 300) begin
            if (pendingQ.size() > 0) begin
                cfu_rsp_valid = 1;
                cfu_rsp_tag   = pendingQ[0];
                cfu_rsp_data  = $urandom;
            end else begin
                cfu_rsp_valid = 0;
            end
            tick();
            guard++;
        end
        cfu_rsp_valid = 0;
        compared++;
        if (guard >= 300) begin
            mismatched++;
            $display("[TB] FAIL drain_timeout: cycles %0d, required under 300", guard);
        end
        compared++;
        if (outstanding !== 3'd0 || idle !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL drain_idle: outstanding %0d idle %0b, required 0 and 1", outstanding, idle);
        end
    endtask

    task automatic test_reset();
        rst = 1;
        tick();
        tick();
        rst = 0;
        compared++;
        if ({cfu_req_valid, cfu_req_tag, cfu_req_funct, cfu_req_operand,
             rsp_valid, rsp_tag, rsp_data, tag_error, outstanding} !== '0) begin
            mismatched++;
            $display("[TB] FAIL reset_outputs: req %0b/%0h/%0h/%0h rsp %0b/%0h/%0h err %0b out %0d, required all 0",
                     cfu_req_valid, cfu_req_tag, cfu_req_funct, cfu_req_operand,
                     rsp_valid, rsp_tag, rsp_data, tag_error, outstanding);
        end
        compared++;
        if (idle !== 1'b1 || cfu_rsp_ready !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL reset_status: idle %0b cfu_rsp_ready %0b, required 1 and 1", idle, cfu_rsp_ready);
        end
        compared++;
        if ({fifoIf.push, fifoIf.potential_push, fifoIf.data_in} !== '0) begin
            mismatched++;
            $display("[TB] FAIL fifo_tieoff: push %0b potential_push %0b data_in %0h, required 0",
                     fifoIf.push, fifoIf.potential_push, fifoIf.data_in);
        end
    endtask

    task automatic test_single_op();
        cfu_req_ready = 1;
        rsp_ready     = 1;
        pushEntry(4'd3, 6'h05, 32'h1234_5678);
        tick();
        compared++;
        if (obsPop !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL single_pop: got %0b, required 1", obsPop);
        end
        compared++;
        if ({cfu_req_valid, cfu_req_tag, cfu_req_funct, cfu_req_operand} !== {1'b1, 4'd3, 6'h05, 32'h1234_5678}) begin
            mismatched++;
            $display("[TB] FAIL single_req: got %0b/%0h/%0h/%0h, required 1/3/5/12345678",
                     cfu_req_valid, cfu_req_tag, cfu_req_funct, cfu_req_operand);
        end
        compared++;
        if (outstanding !== 3'd1) begin
            mismatched++;
            $display("[TB] FAIL single_count_up: got %0d, required 1", outstanding);
        end
        cfu_rsp_valid = 1;
        cfu_rsp_tag   = 4'd3;
        cfu_rsp_data  = 32'hCAFE_F00D;
        tick();
        cfu_rsp_valid = 0;
        compared++;
        if ({rsp_valid, rsp_tag, rsp_data} !== {1'b1, 4'd3, 32'hCAFE_F00D}) begin
            mismatched++;
            $display("[TB] FAIL single_rsp: got %0b/%0h/%0h, required 1/3/cafef00d", rsp_valid, rsp_tag, rsp_data);
        end
        compared++;
        if (outstanding !== 3'd0 || cfu_req_valid !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL single_count_down: outstanding %0d req_valid %0b, required 0 and 0",
                     outstanding, cfu_req_valid);
        end
        tick();
        compared++;
        if (rsp_valid !== 1'b0 || idle !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL single_idle: rsp_valid %0b idle %0b, required 0 and 1", rsp_valid, idle);
        end
    endtask

    task automatic test_credit_limit();
        int pops;
        pops          = 0;
        cfu_req_ready = 1;
        for (int i = 0; i < 6; i++) pushEntry(4'(i), 6'($urandom), $urandom);
        repeat (8) begin
            tick();
            if (obsPop) pops++;
        end
        compared++;
        if (pops !== 4 || outstanding !== 3'd4) begin
            mismatched++;
            $display("[TB] FAIL credit_limit: pops %0d outstanding %0d, required 4 and 4", pops, outstanding);
        end
        cfu_rsp_valid = 1;
        cfu_rsp_tag   = 4'd1;
        cfu_rsp_data  = $urandom;
        tick();
        cfu_rsp_valid = 0;
        compared++;
        if (obsPop !== 1'b0 || outstanding !== 3'd3) begin
            mismatched++;
            $display("[TB] FAIL credit_retire_cycle: pop %0b outstanding %0d, required 0 and 3", obsPop, outstanding);
        end
        tick();
        compared++;
        if (obsPop !== 1'b1 || cfu_req_valid !== 1'b1 || cfu_req_tag !== 4'd4 || outstanding !== 3'd4) begin
            mismatched++;
            $display("[TB] FAIL credit_fifth_pop: pop %0b req %0b tag %0h outstanding %0d, required 1/1/4/4",
                     obsPop, cfu_req_valid, cfu_req_tag, outstanding);
        end
        drainAll();
    endtask

    task automatic test_tag_hazard();
        cfu_req_ready = 1;
        pushEntry(4'd7, 6'h01, 32'hAAAA_0001);
        pushEntry(4'd7, 6'h02, 32'hBBBB_0002);
        tick();
        compared++;
        if (obsPop !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL hazard_first_pop: got %0b, required 1", obsPop);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            compared++;
            if (obsPop !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL hazard_stall[%0d]: pop %0b, required 0", i, obsPop);
            end
        end
        cfu_rsp_valid = 1;
        cfu_rsp_tag   = 4'd7;
        cfu_rsp_data  = 32'h0000_0777;
        tick();
        cfu_rsp_valid = 0;
        compared++;
        if (obsPop !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL hazard_same_cycle: pop %0b, required 0", obsPop);
        end
        tick();
        compared++;
        if (obsPop !== 1'b1 || {cfu_req_valid, cfu_req_funct, cfu_req_operand} !== {1'b1, 6'h02, 32'hBBBB_0002}) begin
            mismatched++;
            $display("[TB] FAIL hazard_repop: pop %0b req %0b/%0h/%0h, required 1 and 1/2/bbbb0002",
                     obsPop, cfu_req_valid, cfu_req_funct, cfu_req_operand);
        end
        drainAll();
    endtask

    task automatic test_backpressure();
        logic [41:0] held;
        cfu_req_ready = 0;
        rsp_ready     = 1;
        pushEntry(4'd2, 6'h11, 32'h2222_2222);
        pushEntry(4'd4, 6'h12, 32'h4444_4444);
        tick();
        compared++;
        if (obsPop !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL bp_first_pop: got %0b, required 1", obsPop);
        end
        held = {4'd2, 6'h11, 32'h2222_2222};
        for (int i = 0; i < 5; i++) begin
            tick();
            compared++;
            if (obsPop !== 1'b0 || cfu_req_valid !== 1'b1
                || {cfu_req_tag, cfu_req_funct, cfu_req_operand} !== held) begin
                mismatched++;
                $display("[TB] FAIL bp_req_hold[%0d]: pop %0b req %0b payload %0h, required 0/1/%0h",
                         i, obsPop, cfu_req_valid, {cfu_req_tag, cfu_req_funct, cfu_req_operand}, held);
            end
        end
        cfu_req_ready = 1;
        tick();
        compared++;
        if (obsPop !== 1'b1 || cfu_req_tag !== 4'd4) begin
            mismatched++;
            $display("[TB] FAIL bp_release_pop: pop %0b tag %0h, required 1 and 4", obsPop, cfu_req_tag);
        end
        tick();
        rsp_ready     = 0;
        cfu_rsp_valid = 1;
        cfu_rsp_tag   = 4'd2;
        cfu_rsp_data  = 32'hD00D_0002;
        tick();
        cfu_rsp_tag   = 4'd4;
        cfu_rsp_data  = 32'hE00E_0004;
        for (int i = 0; i < 3; i++) begin
            tick();
            compared++;
            if (cfu_rsp_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_tag !== 4'd2
                || rsp_data !== 32'hD00D_0002 || outstanding !== 3'd1) begin
                mismatched++;
                $display("[TB] FAIL bp_rsp_hold[%0d]: cfu_rsp_ready %0b rsp %0b/%0h/%0h outstanding %0d, required 0 1/2/d00d0002 1",
                         i, cfu_rsp_ready, rsp_valid, rsp_tag, rsp_data, outstanding);
            end
        end
        cfu_rsp_valid = 0;
        rsp_ready     = 1;
        drainAll();
    endtask

    task automatic test_bogus_tag();
        cfu_rsp_valid = 1;
        cfu_rsp_tag   = 4'd9;
        cfu_rsp_data  = $urandom;
        tick();
        cfu_rsp_valid = 0;
        compared++;
        if (tag_error !== 1'b1 || rsp_valid !== 1'b0 || outstanding !== 3'd0) begin
            mismatched++;
            $display("[TB] FAIL bogus_tag: err %0b rsp_valid %0b outstanding %0d, required 1/0/0",
                     tag_error, rsp_valid, outstanding);
        end
        tick();
        compared++;
        if (tag_error !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL bogus_pulse_width: err %0b, required 0", tag_error);
        end
    endtask

    task automatic test_flush();
        bit required[3];
        cfu_req_ready = 1;
        rsp_ready     = 1;
        pushEntry(4'd1, 6'h21, 32'h1111_0001);
        pushEntry(4'd2, 6'h22, 32'h2222_0002);
        tick();
        tick();
        compared++;
        if (outstanding !== 3'd2) begin
            mismatched++;
            $display("[TB] FAIL flush_setup: outstanding %0d, required 2", outstanding);
        end
        pushEntry(4'd3, 6'h23, 32'h3333_0003);
        pushEntry(4'd4, 6'h24, 32'h4444_0004);
        flush = 1;
        tick();
        flush = 0;
        compared++;
        if (obsPop !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL flush_wins: pop %0b, required 0", obsPop);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            compared++;
            if (obsPop !== 1'b0 || idle !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL flush_hold[%0d]: pop %0b idle %0b, required 0 and 0", i, obsPop, idle);
            end
        end
        cfu_rsp_valid = 1;
        cfu_rsp_tag   = 4'd1;
        cfu_rsp_data  = 32'hF1F1_F1F1;
        tick();
        cfu_rsp_tag   = 4'd2;
        cfu_rsp_data  = 32'hF2F2_F2F2;
        tick();
        cfu_rsp_valid = 0;
        required[0] = 0;
        required[1] = 0;
        required[2] = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            compared++;
            if (obsPop !== required[i]) begin
                mismatched++;
                $display("[TB] FAIL flush_resume[%0d]: pop %0b, required %0b", i, obsPop, required[i]);
            end
            if (i == 1) begin
                compared++;
                if (idle !== 1'b1) begin
                    mismatched++;
                    $display("[TB] FAIL flush_back_to_run: idle %0b, required 1", idle);
                end
            end
        end
        flush = 1;
        tick();
        flush = 0;
        tick();
        rst = 1;
        tick();
        rst = 0;
        compared++;
        if ({cfu_req_valid, cfu_req_tag, cfu_req_funct, cfu_req_operand,
             rsp_valid, rsp_tag, rsp_data, tag_error, outstanding} !== '0) begin
            mismatched++;
            $display("[TB] FAIL flush_reset: req %0b/%0h rsp %0b/%0h err %0b out %0d, required all 0",
                     cfu_req_valid, cfu_req_tag, rsp_valid, rsp_data, tag_error, outstanding);
        end
        tick();
        compared++;
        if (obsPop !== 1'b1 || cfu_req_tag !== 4'd4) begin
            mismatched++;
            $display("[TB] FAIL post_reset_pop: pop %0b tag %0h, required 1 and 4", obsPop, cfu_req_tag);
        end
        drainAll();
    endtask

    task automatic test_random();
        int r;
        logic [3:0] t;
        for (int cyc = 0; cyc < 400; cyc++) begin
            cfu_req_ready = ($urandom_range(0, 3) != 0);
            rsp_ready     = ($urandom_range(0, 3) != 0);
            flush         = ($urandom_range(0, 40) == 0);
            if ($urandom_range(0, 1) == 1 && fifoQ.size() < 6)
                pushEntry(4'($urandom_range(0, 7)), 6'($urandom), $urandom);
            r = $urandom_range(0, 9);
            cfu_rsp_valid = 0;
            if (r < 5 && pendingQ.size() > 0) begin
                cfu_rsp_valid = 1;
                cfu_rsp_tag   = pendingQ[$urandom_range(0, pendingQ.size() - 1)];
                cfu_rsp_data  = $urandom;
            end else if (r == 9) begin
                t = 4'($urandom_range(0, 15));
                if (!mBusy[t]) begin
                    cfu_rsp_valid = 1;
                    cfu_rsp_tag   = t;
                    cfu_rsp_data  = $urandom;
                end
            end
            tick();
            compared++;
            if (obsPop !== expPop) begin
                mismatched++;
                $display("[TB] FAIL rnd_pop @%0d: got %0b, required %0b", cyc, obsPop, expPop);
            end
            compared++;
            if (cfu_req_valid !== mReqValid
                || (mReqValid && {cfu_req_tag, cfu_req_funct, cfu_req_operand} !== mReq)) begin
                mismatched++;
                $display("[TB] FAIL rnd_req @%0d: got %0b/%0h, required %0b/%0h", cyc, cfu_req_valid,
                         {cfu_req_tag, cfu_req_funct, cfu_req_operand}, mReqValid, mReq);
            end
            compared++;
            if (rsp_valid !== mRspValid || (mRspValid && {rsp_tag, rsp_data} !== {mRspTag, mRspData})) begin
                mismatched++;
                $display("[TB] FAIL rnd_rsp @%0d: got %0b/%0h/%0h, required %0b/%0h/%0h", cyc,
                         rsp_valid, rsp_tag, rsp_data, mRspValid, mRspTag, mRspData);
            end
            compared++;
            if (tag_error !== mTagErr || outstanding !== 3'(mCount)) begin
                mismatched++;
                $display("[TB] FAIL rnd_status @%0d: err %0b out %0d, required %0b %0d", cyc,
                         tag_error, outstanding, mTagErr, mCount);
            end
            compared++;
            if (idle !== (!mDrain && mCount == 0 && !mReqValid && !mRspValid)
                || cfu_rsp_ready !== (!mRspValid || rsp_ready)) begin
                mismatched++;
                $display("[TB] FAIL rnd_ready_idle @%0d: idle %0b cfu_rsp_ready %0b, required %0b %0b", cyc,
                         idle, cfu_rsp_ready, (!mDrain && mCount == 0 && !mReqValid && !mRspValid),
                         (!mRspValid || rsp_ready));
            end
        end
        drainAll();
    endtask

    initial begin
        rst           = 1;
        flush         = 0;
        cfu_req_ready = 0;
        cfu_rsp_valid = 0;
        cfu_rsp_tag   = '0;
        cfu_rsp_data  = '0;
        rsp_ready     = 1;
        modelReset();
        refreshFifo();

        test_reset();
        test_single_op();
        test_credit_limit();
        test_tag_hazard();
        test_backpressure();
        test_bogus_tag();
        test_flush();
        test_random();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
